// File: rtl/reset_sequencer_pkg.sv
// Shared types and helpers for the reset sequencer.
package reset_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_RESET     = 2'd0,
      ST_WAIT_LOCK = 2'd1,
      ST_HOLD      = 2'd2,
      ST_RUN       = 2'd3
   } t_rst_seq_state;

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int unsigned f_cnt_width(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sync_bit.sv
// N-stage single-bit synchronizer, async active-low reset to 0.
module sync_bit #(
   parameter int unsigned par_stages = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [par_stages-1:0] chain;

   // Shift the asynchronous input through the flop chain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain <= '0;
      end else begin
         chain <= {chain[par_stages-2:0], d};
      end
   end

   assign q = chain[par_stages-1];

endmodule

// File: rtl/reset_sequencer.sv
// Sequences the downstream synchronous reset from board reset and MMCM lock.
module reset_sequencer
   import reset_sequencer_pkg::*;
#(
   parameter int unsigned par_sync_stages        = 2,
   parameter int unsigned par_lock_stable_cycles = 1024,
   parameter int unsigned par_hold_cycles        = 16,
   parameter int unsigned par_cnt_width          = 8
) (
   input  logic                     i_clk_mhz,
   input  logic                     i_rstn_mhz,
   input  logic                     i_locked,
   input  logic                     i_sw_rst_req,
   output logic                     o_rst_mhz,
   output logic                     o_rst_done,
   output logic [par_cnt_width-1:0] o_lock_lost_cnt
);

   localparam int unsigned STABLE_W = f_cnt_width(par_lock_stable_cycles);
   localparam int unsigned HOLD_W   = f_cnt_width(par_hold_cycles);
   localparam logic [STABLE_W-1:0]      STABLE_LAST = STABLE_W'(par_lock_stable_cycles - 1);
   localparam logic [HOLD_W-1:0]        HOLD_LAST   = HOLD_W'(par_hold_cycles - 1);
   localparam logic [par_cnt_width-1:0] CNT_MAX     = '1;

   logic [par_sync_stages-1:0] rel_chain;
   logic                       s_rst_int;
   logic                       s_locked;

   t_rst_seq_state             state;
   t_rst_seq_state             state_nxt;
   logic [STABLE_W-1:0]        stable_cnt;
   logic [STABLE_W-1:0]        stable_nxt;
   logic [HOLD_W-1:0]          hold_cnt;
   logic [HOLD_W-1:0]          hold_nxt;
   logic [par_cnt_width-1:0]   lost_nxt;
   logic                       rst_nxt;
   logic                       done_nxt;

   // Reset-release chain: asserts at once, releases after par_sync_stages edges.
   always_ff @(posedge i_clk_mhz or negedge i_rstn_mhz) begin
      if (!i_rstn_mhz) begin
         rel_chain <= '0;
      end else begin
         rel_chain <= {rel_chain[par_sync_stages-2:0], 1'b1};
      end
   end

   assign s_rst_int = ~rel_chain[par_sync_stages-1];

   // Bring the MMCM lock into the local clock domain.
   sync_bit #(
      .par_stages (par_sync_stages)
   ) u_lock_sync (
      .clk   (i_clk_mhz),
      .rst_n (i_rstn_mhz),
      .d     (i_locked),
      .q     (s_locked)
   );

   // State, counters and registered outputs; o_rst_mhz is async-set.
   always_ff @(posedge i_clk_mhz or negedge i_rstn_mhz) begin
      if (!i_rstn_mhz) begin
         state           <= ST_RESET;
         stable_cnt      <= '0;
         hold_cnt        <= '0;
         o_lock_lost_cnt <= '0;
         o_rst_mhz       <= 1'b1;
         o_rst_done      <= 1'b0;
      end else begin
         state           <= state_nxt;
         stable_cnt      <= stable_nxt;
         hold_cnt        <= hold_nxt;
         o_lock_lost_cnt <= lost_nxt;
         o_rst_mhz       <= rst_nxt;
         o_rst_done      <= done_nxt;
      end
   end

   // Next-state, counter and output decode.
   always_comb begin
      state_nxt  = state;
      stable_nxt = stable_cnt;
      hold_nxt   = hold_cnt;
      lost_nxt   = o_lock_lost_cnt;

      if (s_rst_int) begin
         state_nxt  = ST_RESET;
         stable_nxt = '0;
         hold_nxt   = '0;
      end else begin
         unique case (state)
            ST_RESET: begin
               state_nxt  = ST_WAIT_LOCK;
               stable_nxt = '0;
               hold_nxt   = '0;
            end
            ST_WAIT_LOCK: begin
               hold_nxt = '0;
               if (!s_locked) begin
                  stable_nxt = '0;
               end else if (stable_cnt == STABLE_LAST) begin
                  stable_nxt = '0;
                  state_nxt  = ST_HOLD;
               end else begin
                  stable_nxt = stable_cnt + STABLE_W'(1);
               end
            end
            ST_HOLD: begin
               stable_nxt = '0;
               if (!s_locked) begin
                  hold_nxt  = '0;
                  state_nxt = ST_WAIT_LOCK;
               end else if (hold_cnt == HOLD_LAST) begin
                  hold_nxt  = '0;
                  state_nxt = ST_RUN;
               end else begin
                  hold_nxt = hold_cnt + HOLD_W'(1);
               end
            end
            ST_RUN: begin
               stable_nxt = '0;
               hold_nxt   = '0;
               if (!s_locked) begin
                  state_nxt = ST_WAIT_LOCK;
                  if (o_lock_lost_cnt != CNT_MAX) begin
                     lost_nxt = o_lock_lost_cnt + par_cnt_width'(1);
                  end
               end else if (i_sw_rst_req) begin
                  state_nxt = ST_HOLD;
               end
            end
            default: begin
               state_nxt  = ST_RESET;
               stable_nxt = '0;
               hold_nxt   = '0;
            end
         endcase
      end

      rst_nxt  = (state_nxt != ST_RUN);
      done_nxt = (state_nxt == ST_RUN) && (state != ST_RUN);
   end

endmodule
